comparador_serial_di: RTL

- Bit-serial magnitude comparator that scans operands right-to-left, LSB first.
- It complements the left-to-right cascaded comparator cells. The same (M,N) cascade encoding is produced, but one bit is evaluated per clock instead of one cell per bit.
- It is used where a full cell chain costs too much area and WIDTH cycles of latency are acceptable.
- Operands are loaded in parallel through a start/ready handshake. The result is presented as both the cascade pair and one-hot gt/eq/lt flags.

---
 rtl/comparador_serial_di.sv | 134 +++++++++++++
 1 files changed

// File: rtl/comparador_serial_di.sv
// comparador_serial_di
// ---------------------------------------------------------------------------
// Bit-serial magnitude comparator. It scans the operands from the LSB up to
// the MSB, one bit per clock. The result uses the same (M,N) cascade encoding
// as the cascaded comparator cells:
//   (1,1) equal, (1,0) A>B, (0,1) A<B, (0,0) no result since reset.
//
// Parameters:
//   WIDTH  : operand width (2..32)
//   SIGNED : 0 = unsigned compare, 1 = two's-complement compare
//
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high reset
//   start  : load request for A/B; taken only while ready=1
//   A, B   : operands, sampled on the accepting edge
//   ready  : idle and able to accept start
//   done   : one-cycle pulse when M/N/gt/eq/lt have just been updated
//   M, N   : cascade result pair, held until the next completion
//   gt, eq, lt : one-hot decoded result, held until the next completion
//
// Handshake: a compare begins on any rising edge where start=1 and ready=1.
// While ready=0, start is ignored. done rises together with ready, so a start
// presented in the done cycle is accepted back-to-back.
// ---------------------------------------------------------------------------
module comparador_serial_di #(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             done,
  output logic             M,
  output logic             N,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // The counter only has to reach WIDTH-1. It is never allowed to wrap.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [CW-1:0]    cnt;
  logic             work_m;
  logic             work_n;

  logic             last_bit;
  logic             invert;
  logic             m_nx;
  logic             n_nx;

  // Decision for the current bit. Because bits are scanned upward, a
  // differing bit overwrites whatever the lower bits decided. An equal bit
  // keeps the earlier decision. In signed mode the sign bit has the opposite
  // sense, because a 1 in the sign bit marks the smaller value.
  always_comb begin
    last_bit = (cnt == LAST_BIT);
    invert   = (SIGNED != 0) && last_bit;
    m_nx     = work_m;
    n_nx     = work_n;
    if (sh_a[0] && !sh_b[0]) begin
      m_nx = !invert;
      n_nx = invert;
    end else if (!sh_a[0] && sh_b[0]) begin
      m_nx = invert;
      n_nx = !invert;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      ready  <= 1'b1;
      done   <= 1'b0;
      M      <= 1'b0;
      N      <= 1'b0;
      gt     <= 1'b0;
      eq     <= 1'b0;
      lt     <= 1'b0;
      sh_a   <= '0;
      sh_b   <= '0;
      cnt    <= '0;
      work_m <= 1'b0;
      work_n <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sh_a   <= A;
            sh_b   <= B;
            work_m <= 1'b1;
            work_n <= 1'b1;
            cnt    <= '0;
            ready  <= 1'b0;
            state  <= RUN;
          end
        end
        RUN: begin
          work_m <= m_nx;
          work_n <= n_nx;
          sh_a   <= {1'b0, sh_a[WIDTH-1:1]};
          sh_b   <= {1'b0, sh_b[WIDTH-1:1]};
          if (last_bit) begin
            // The final bit is folded straight into the held outputs.
            M     <= m_nx;
            N     <= n_nx;
            gt    <= m_nx && !n_nx;
            eq    <= m_nx && n_nx;
            lt    <= !m_nx && n_nx;
            done  <= 1'b1;
            ready <= 1'b1;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
